// File: rtl/gate_exerciser.sv
// gate_exerciser: drives a 2-input gate through its truth table and checks y against FUNC
module gate_exerciser #(
    parameter int         SETTLE_CYCLES = 2,
    parameter logic [3:0] FUNC          = 4'b1110,
    parameter int         LOOPS         = 1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic       y,
    output logic       a,
    output logic       b,
    output logic       busy,
    output logic       done,
    output logic       pass,
    output logic [3:0] fail_mask,
    output logic [7:0] err_count
);
    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] SETTLE = 2'd1;
    localparam logic [1:0] SAMPLE = 2'd2;
    localparam logic [1:0] DONE   = 2'd3;
    localparam int SW = $clog2(SETTLE_CYCLES + 1);
    localparam int LW = $clog2(LOOPS + 1);

    logic [1:0]    state_q, state_d, row_q, row_d;
    logic [SW-1:0] settle_q, settle_d;
    logic [LW-1:0] loop_q, loop_d;
    logic          a_q, a_d, b_q, b_d, pass_q, pass_d;
    logic [3:0]    mask_q, mask_d;
    logic [7:0]    err_q, err_d;

    always_comb begin
        state_d  = state_q;
        row_d    = row_q;
        settle_d = settle_q;
        loop_d   = loop_q;
        a_d      = a_q;
        b_d      = b_q;
        pass_d   = pass_q;
        mask_d   = mask_q;
        err_d    = err_q;
        case (state_q)
            IDLE: if (start) begin
                state_d  = SETTLE;
                row_d    = 2'd0;
                loop_d   = '0;
                settle_d = '0;
                mask_d   = 4'd0;
                err_d    = 8'd0;
                pass_d   = 1'b0;
                {a_d, b_d} = 2'b00;
            end
            SETTLE: begin
                state_d  = (settle_q == SW'(SETTLE_CYCLES - 1)) ? SAMPLE : SETTLE;
                settle_d = (settle_q == SW'(SETTLE_CYCLES - 1)) ? '0 : settle_q + 1'b1;
            end
            SAMPLE: begin
                if (y != FUNC[row_q]) begin
                    mask_d[row_q] = 1'b1;
                    err_d = (err_q == 8'hFF) ? err_q : err_q + 8'd1;
                end
                if (row_q != 2'd3) begin
                    state_d    = SETTLE;
                    row_d      = row_q + 2'd1;
                    {a_d, b_d} = row_q + 2'd1;
                end else if (loop_q != LW'(LOOPS - 1)) begin
                    state_d    = SETTLE;
                    loop_d     = loop_q + 1'b1;
                    row_d      = 2'd0;
                    {a_d, b_d} = 2'b00;
                end else begin
                    state_d    = DONE;
                    {a_d, b_d} = 2'b00;
                    pass_d     = ~|mask_d;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            row_q    <= 2'd0;
            settle_q <= '0;
            loop_q   <= '0;
            a_q      <= 1'b0;
            b_q      <= 1'b0;
            pass_q   <= 1'b0;
            mask_q   <= 4'd0;
            err_q    <= 8'd0;
        end else begin
            state_q  <= state_d;
            row_q    <= row_d;
            settle_q <= settle_d;
            loop_q   <= loop_d;
            a_q      <= a_d;
            b_q      <= b_d;
            pass_q   <= pass_d;
            mask_q   <= mask_d;
            err_q    <= err_d;
        end
    end

    assign a         = a_q;
    assign b         = b_q;
    assign busy      = (state_q == SETTLE) || (state_q == SAMPLE);
    assign done      = (state_q == DONE);
    assign pass      = pass_q;
    assign fail_mask = mask_q;
    assign err_count = err_q;
endmodule

// File: tb/tb_gate_exerciser.sv
// tb_gate_exerciser: scoreboard bench for gate_exerciser with a default and a 3-sweep instance
module tb_gate_exerciser;
    localparam int S = 2;

    typedef struct {
        logic [3:0] mask;
        logic [7:0] err;
        logic       pass;
        int         dcyc;
    } exp_t;

    logic clk = 1'b0, rst_n = 1'b0, start0 = 1'b0, start1 = 1'b0, sel = 1'b0;
    int   mode = 0;
    logic y0, a0, b0, busy0, done0, pass0, y1, a1, b1, busy1, done1, pass1;
    logic [3:0] mask0, mask1;
    logic [7:0] err0, err1;
    int checks = 0, passed = 0;
    exp_t sb[$];

    always #5 clk = ~clk;

    function automatic logic gate(input int m, input logic x, input logic z);
        return (m == 0) ? (x | z) : (m == 1) ? 1'b0 : (m == 2) ? (x & z) : 1'b1;
    endfunction

    assign y0 = gate(mode, a0, b0);
    assign y1 = gate(mode, a1, b1);

    gate_exerciser dut0 (
        .clk(clk), .rst_n(rst_n), .start(start0), .y(y0), .a(a0), .b(b0), .busy(busy0),
        .done(done0), .pass(pass0), .fail_mask(mask0), .err_count(err0)
    );
    gate_exerciser #(.LOOPS(3)) dut1 (
        .clk(clk), .rst_n(rst_n), .start(start1), .y(y1), .a(a1), .b(b1), .busy(busy1),
        .done(done1), .pass(pass1), .fail_mask(mask1), .err_count(err1)
    );

    wire       o_a    = sel ? a1 : a0;
    wire       o_b    = sel ? b1 : b0;
    wire       o_busy = sel ? busy1 : busy0;
    wire       o_done = sel ? done1 : done0;
    wire       o_pass = sel ? pass1 : pass0;
    wire [3:0] o_mask = sel ? mask1 : mask0;
    wire [7:0] o_err  = sel ? err1 : err0;

    task automatic test_reset();
        #3;
        checks++;
        if ({a0, b0, busy0, done0, pass0, mask0, err0} !== 17'd0)
            $display("FAIL reset_values got %h exp 0", {a0, b0, busy0, done0, pass0, mask0, err0});
        else passed++;
        @(negedge clk) rst_n = 1'b1;
    endtask

    task automatic run(input logic s, input int m, input logic [3:0] em, input logic [7:0] ee,
                       input logic ep, input string nm);
        int loops = s ? 3 : 1;
        int dc = 4 * loops * (S + 1) + 1;
        int k = 1, got = 0, busy_n = 0;
        bit seq_ok = 1;
        logic [1:0] row;
        exp_t e;
        sb.push_back('{em, ee, ep, dc});
        sel = s;
        mode = m;
        @(negedge clk) begin start0 = !s; start1 = s; end
        @(negedge clk) begin start0 = 1'b0; start1 = 1'b0; end
        while (k <= 200) begin
            if (o_done) begin got = k; break; end
            if (o_busy) busy_n++;
            row = 2'(((k - 1) / (S + 1)) % 4);
            if ({o_a, o_b} !== row) seq_ok = 0;
            @(negedge clk);
            k++;
        end
        e = sb.pop_front();
        checks++;
        if (got !== e.dcyc) $display("FAIL %s done_cycle got %0d exp %0d", nm, got, e.dcyc);
        else passed++;
        checks++;
        if (busy_n !== e.dcyc - 1) $display("FAIL %s busy_cycles got %0d exp %0d", nm, busy_n, e.dcyc - 1);
        else passed++;
        checks++;
        if (!seq_ok) $display("FAIL %s ab_sequence got bad exp 00,01,10,11 x%0d", nm, S + 1);
        else passed++;
        checks++;
        if (o_mask !== e.mask) $display("FAIL %s fail_mask got %b exp %b", nm, o_mask, e.mask);
        else passed++;
        checks++;
        if (o_err !== e.err) $display("FAIL %s err_count got %0d exp %0d", nm, o_err, e.err);
        else passed++;
        checks++;
        if (o_pass !== e.pass) $display("FAIL %s pass got %b exp %b", nm, o_pass, e.pass);
        else passed++;
        @(negedge clk);
        checks++;
        if ({o_done, o_busy, o_pass, o_mask, o_err} !== {2'b00, e.pass, e.mask, e.err})
            $display("FAIL %s after_done got %h exp %h", nm, {o_done, o_busy, o_pass, o_mask, o_err},
                     {2'b00, e.pass, e.mask, e.err});
        else passed++;
    endtask

    task automatic test_abort_restart();
        bit saw_done = 0;
        sel = 1'b0;
        mode = 1;
        @(negedge clk) start0 = 1'b1;
        @(negedge clk) start0 = 1'b0;
        @(negedge clk);
        @(negedge clk) start0 = 1'b1;
        @(negedge clk) start0 = 1'b0;
        checks++;
        if ({a0, b0} !== 2'b01) $display("FAIL start_ignored got %b exp 01", {a0, b0});
        else passed++;
        repeat (4) begin
            @(negedge clk);
            if (done0) saw_done = 1;
        end
        checks++;
        if ({a0, b0, busy0, mask0, err0} !== {3'b101, 4'b0010, 8'd1})
            $display("FAIL pre_abort got %h exp %h", {a0, b0, busy0, mask0, err0}, {3'b101, 4'b0010, 8'd1});
        else passed++;
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if ({a0, b0, busy0, done0, pass0, mask0, err0} !== 17'd0)
            $display("FAIL async_reset got %h exp 0", {a0, b0, busy0, done0, pass0, mask0, err0});
        else passed++;
        repeat (5) begin
            @(negedge clk);
            if (done0) saw_done = 1;
        end
        checks++;
        if (saw_done) $display("FAIL abort_no_done got 1 exp 0");
        else passed++;
        rst_n = 1'b1;
        run(1'b0, 0, 4'b0000, 8'd0, 1'b1, "restart");
    endtask

    initial begin
        test_reset();
        run(1'b0, 0, 4'b0000, 8'd0, 1'b1, "or_gate");
        run(1'b0, 1, 4'b1110, 8'd3, 1'b0, "stuck0");
        run(1'b0, 2, 4'b0110, 8'd2, 1'b0, "and_gate");
        run(1'b1, 3, 4'b0001, 8'd3, 1'b0, "loops3");
        test_abort_restart();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule

// File: doc/gate_exerciser.md
# gate_exerciser

Self-checking stimulus and response stage for the two-input logic gate cells in this library. It drives the gate's `a`/`b` inputs through the full 2-input truth table and samples the gate's `y` output after a programmable settle time. It compares each sample against an expected truth table and reports a per-row failure mask, an error count and a pass/done handshake. It sits directly around the gate under test: upstream of its inputs and downstream of its output.

## Interface
Parameters:
- `SETTLE_CYCLES`, default 2: cycles `a`/`b` are held before `y` is sampled. Legal range is 1 or more.
- `FUNC`, default 4'b1110: expected `y` per row; bit `r` is the expected value for row `r = {a,b}` (4'b1110 = OR).
- `LOOPS`, default 1: number of full truth-table sweeps per run. Legal range is 1 or more.

Ports:
- `clk`  in  1  rising-edge clock
- `rst_n`  in  1  asynchronous, active-low reset
- `start`  in  1  run request; sampled only in IDLE
- `y`  in  1  output of the gate under test
- `a`  out  1  gate input A, registered; equals row bit 1
- `b`  out  1  gate input B, registered; equals row bit 0
- `busy`  out  1  high while a run is in progress (SETTLE/SAMPLE)
- `done`  out  1  single-cycle pulse at end of run
- `pass`  out  1  high when the last completed run had no mismatches
- `fail_mask`  out  4  bit `r` set if row `r` mismatched in any sweep of the run
- `err_count`  out  8  total mismatches in the run, saturating at 255

## Operation
- The block has four states: IDLE, SETTLE, SAMPLE, DONE.
- **Reset** (asynchronous, any state): state goes to IDLE; the row, loop and settle counters clear.
  - `a`=`b`=0, `busy`=0, `done`=0, `pass`=0, `fail_mask`=0, `err_count`=0.
- **IDLE:** `a`=`b`=0.
  - `start`=1 at a clock edge moves the state to SETTLE with row=0, loop=0 and settle count=0.
  - The same edge clears `fail_mask`, `err_count` and `pass`.
- **SETTLE:** `a`,`b` = row. The settle count increments each cycle; after SETTLE_CYCLES cycles in SETTLE the state moves to SAMPLE.
- **SAMPLE:** lasts one cycle. At the closing edge, `y` is compared with `FUNC[row]`.
  - On mismatch: `fail_mask[row]`←1 and `err_count`←`err_count`+1, holding at 255 once it reaches 255.
  - If row<3: row←row+1, back to SETTLE.
  - If row=3 and loop<LOOPS-1: loop←loop+1, row←0, back to SETTLE.
  - Otherwise go to DONE.
- **DONE:** lasts one cycle. `done`=1, `busy`=0 and `a`=`b`=0. `pass` is loaded with NOR of the final `fail_mask` (including any update at the last SAMPLE edge). The state then returns to IDLE.
- `pass`, `fail_mask` and `err_count` hold their values from the end of a run until the next accepted `start` or reset.
- `start` is ignored outside IDLE, so it is a don't-care during SETTLE, SAMPLE and DONE. If `start` is held high continuously, a new run begins on the edge after DONE.
- `y` is treated as asynchronous to stimulus only through the settle time; the block does not synchronize `y`.

## Timing
- `a`/`b` change only on the edge that enters SETTLE (or enters IDLE/DONE, where they are 0). They are stable through every SAMPLE cycle.
- Each row takes SETTLE_CYCLES+1 cycles.
- A run occupies 4·LOOPS·(SETTLE_CYCLES+1) cycles of `busy`=1, starting on the edge that accepts `start`.
- `done` is high in the next cycle, which is cycle 4·LOOPS·(SETTLE_CYCLES+1)+1 after the start edge. With the defaults that is cycle 13.
- `y` is sampled exactly SETTLE_CYCLES+1 edges after `a`/`b` are updated.
- A reset asserted mid-run aborts immediately. No `done` pulse is produced, and all outputs go to their reset values.

## Test plan
1. **Reset values:** assert `rst_n`=0 mid-cycle while outputs are nonzero. Required: `a`,`b`,`busy`,`done`,`pass`,`fail_mask`,`err_count` all go to 0 without waiting for a clock edge.
2. **Good OR gate with defaults:** connect `y`=`a`|`b` and pulse `start` for one cycle. Required:
   - `a`/`b` step through 00,01,10,11, each held for 3 cycles.
   - `busy` stays high for 12 cycles.
   - `done` pulses in cycle 13 with `pass`=1, `fail_mask`=0000, `err_count`=0.
3. **Stuck-at-0 output:** tie `y`=0 with defaults. Required: `fail_mask`=4'b1110, `err_count`=3, `pass`=0.
4. **Wrong gate:** connect `y`=`a`&`b`. Required: `fail_mask`=4'b0110, `err_count`=2, `pass`=0.
5. **Multiple sweeps:** tie `y`=1 with LOOPS=3. Required: `fail_mask`=4'b0001, `err_count`=3, `done` in cycle 37 after the start edge.
6. **Abort and restart:** pulse `start` during a run (no effect), then assert reset during row 2. Required: no `done` pulse and all outputs 0. A following `start` produces a clean full run with the same results as scenario 2.
